data_cache_controller: RTL and testbench
========================================

# data_cache_controller

Direct-mapped, write-back data cache controller placed between the CPU load/store path and the 256-byte, 4-byte-block data memory. Byte requests from the CPU are served from an 8-entry block cache. On a miss, the controller sequences the block memory through an optional write-back and then a block fetch. It stalls the CPU with `busywait` for the whole miss sequence.

## Interface
- `NUM_SETS`, default 8: cache entries; index width is log2(NUM_SETS) = 3.
- `TAG_W`, default 3: tag width, i.e. 8 − 2 (offset) − index width.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) forces the reset state immediately.
- `read`  in  1  CPU byte read request; held until `busywait` = 0.
- `write`  in  1  CPU byte write request; held until `busywait` = 0.
- `address`  in  8  CPU byte address: tag [7:5], index [4:2], offset [1:0].
- `writedata`  in  8  CPU store byte.
- `readdata`  out  8  CPU load byte.
- `busywait`  out  1  CPU stall.
- `mem_read`  out  1  block read request to memory.
- `mem_write`  out  1  block write request to memory.
- `mem_address`  out  6  block address {tag, index}.
- `mem_writedata`  out  32  victim block; byte 0 in [7:0].
- `mem_readdata`  in  32  fetched block; byte 0 in [7:0].
- `mem_busywait`  in  1  memory busy. It rises combinationally with `mem_read`/`mem_write` and falls when the transfer completes.

## Operation
- Per entry: `valid`, `dirty`, `tag[2:0]`, `data[31:0]`.
- Hit = `valid[index]` && `tag[index]` == `address[7:5]`. Hit is combinational.
- States:
  - IDLE: default.
  - WRITEBACK: `mem_write`=1, `mem_address`={stored tag, index}, `mem_writedata`=stored block.
  - FETCH: `mem_read`=1, `mem_address`={address tag, index}.
  - UPDATE: single cycle.
- Transitions:
  - IDLE, request, miss, dirty → WRITEBACK.
  - IDLE, request, miss, clean → FETCH.
  - WRITEBACK → FETCH on a clock edge with `mem_busywait`=0, provided the state has been held at least one cycle.
  - FETCH → UPDATE under the same condition.
  - UPDATE → IDLE.
- UPDATE writes `mem_readdata` into the entry and sets valid=1, dirty=0, tag=request tag. The request then hits in IDLE.
- Read hit: `readdata` = data[index] byte selected by `address[1:0]`. It is combinational from the address.
- Write hit: at the clock edge, `writedata` is written into the selected byte and dirty[index] is set to 1.
- `busywait` = (`read`^`write`) && !(state==IDLE && hit). It is combinational.
- `read` and `write` both high is treated as no access: no state change, `busywait`=0. This matches the memory's own rule.
- Outside WRITEBACK/FETCH, `mem_read`=`mem_write`=0. `mem_address` and `mem_writedata` are don't-care but must be stable within a state.
- Reset (`reset`=0):
  - state=IDLE.
  - All valid=0 and dirty=0.
  - `mem_read`=`mem_write`=0 and `busywait`=0.
  - `readdata` is forced to 0x00.
  - Data/tag arrays are not cleared.

## Timing
- Read hit: zero stall cycles. `busywait` stays 0 and data is valid in the same cycle.
- Write hit: zero stall cycles. The byte is committed at the edge that ends the request cycle.
- Clean miss: FETCH for N_mem cycles, then UPDATE for 1 cycle, then the hit cycle. `busywait` stays high until the IDLE hit.
- Dirty miss: WRITEBACK cost plus the clean-miss cost.
- Request inputs are sampled only in IDLE. During a miss, the CPU must hold `address`/`writedata` stable.
- `mem_*` request outputs are registered state decodes. They change only on clock edges or on reset.
- Reset mid-miss: the requests drop immediately and all entries are invalid. The partially issued memory transfer is abandoned. A write-back in flight may still commit inside the memory; this is acceptable.
- Index wrap: addresses 0x00 and 0xE0 share index 0 and conflict. No replacement choice exists.

## Structure
- Package `cache_pkg` holds:
  - Offset, index, and tag widths.
  - Block width 32.
  - State enum IDLE/WRITEBACK/FETCH/UPDATE.
  - Address-field extraction helpers.
- Sub-module `cache_storage`: valid/dirty/tag/data arrays with reset-clear of valid/dirty, a byte-write port, and a block-fill port.
- `data_cache_controller` holds the FSM, hit logic, and memory handshake.

## Test plan
- Reset, then read 0x05 → miss, clean.
  - FETCH issues `mem_address`=0x01.
  - After UPDATE, `readdata` = byte 1 of memory block 1.
  - `busywait` falls in the hit cycle.
- Write 0xAB to 0x05 after the previous scenario → zero stall, dirty[1]=1. Then read 0x05 → 0xAB, zero stall.
- Read 0xE5 (same index, tag 7) with entry 1 dirty:
  - WRITEBACK first, with `mem_address`=0x01 and `mem_writedata[15:8]`=0xAB.
  - Then FETCH with `mem_address`=0x39.
  - Result: dirty[1]=0, tag=7.
- Miss to a clean entry → no WRITEBACK; `mem_write` never asserts.
- Assert `reset`=0 in the middle of FETCH:
  - `mem_read` and `busywait` drop without waiting for a clock edge.
  - The next read of the same address misses again.
- `read`=`write`=1 on any address → `busywait`=0, no memory request, cache contents unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state type and address-field helpers for the data cache
package cache_pkg;
  localparam int ADDR_WIDTH     = 8;
  localparam int OFFSET_WIDTH   = 2;
  localparam int INDEX_WIDTH    = 3;
  localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int BLOCK_WIDTH    = 32;
  localparam int MEM_ADDR_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } cache_state_e;

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic logic [OFFSET_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFSET_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/data_cache_controller_if.sv
// rtl/data_cache_controller_if.sv - CPU load/store and block-memory signals of the data cache
interface data_cache_controller_if;
  import cache_pkg::*;

  logic                      read;
  logic                      write;
  logic [ADDR_WIDTH-1:0]     address;
  logic [7:0]                writedata;
  logic [7:0]                readdata;
  logic                      busywait;
  logic                      mem_read;
  logic                      mem_write;
  logic [MEM_ADDR_WIDTH-1:0] mem_address;
  logic [BLOCK_WIDTH-1:0]    mem_writedata;
  logic [BLOCK_WIDTH-1:0]    mem_readdata;
  logic                      mem_busywait;

  // master is the environment (CPU and block memory), slave is the cache
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/cache_storage.sv
// rtl/cache_storage.sv - valid/dirty/tag/data arrays with byte-write and block-fill ports
module cache_storage
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int TAG_W    = TAG_WIDTH,
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        index_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  output logic                    valid_o,
  output logic                    dirty_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [BLOCK_WIDTH-1:0]  data_o,
  input  logic                    byte_we_i,
  input  logic [7:0]              byte_i,
  input  logic                    fill_we_i,
  input  logic [TAG_W-1:0]        fill_tag_i,
  input  logic [BLOCK_WIDTH-1:0]  fill_data_i
);
  logic [NUM_SETS-1:0]    valid_q;
  logic [NUM_SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_SETS];
  logic [BLOCK_WIDTH-1:0] data_q [NUM_SETS];

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byte_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits make them meaningful
  always_ff @(posedge clock) begin
    if (fill_we_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_data_i;
    end else if (byte_we_i) begin
      data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_i;
    end
  end
endmodule

// File: rtl/data_cache_controller.sv
// rtl/data_cache_controller.sv - direct-mapped write-back cache: hit logic, miss FSM, memory handshake
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int TAG_W    = TAG_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  data_cache_controller_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_SETS);

  cache_state_e              state_q;
  logic                      held_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [BLOCK_WIDTH-1:0]    mem_wdata_q;
  logic [BLOCK_WIDTH-1:0]    fill_q;

  logic [TAG_W-1:0]          req_tag;
  logic [IDX_W-1:0]          req_idx;
  logic [OFFSET_WIDTH-1:0]   req_off;
  logic                      line_valid;
  logic                      line_dirty;
  logic [TAG_W-1:0]          line_tag;
  logic [BLOCK_WIDTH-1:0]    line_data;
  logic                      req;
  logic                      hit;
  logic                      in_idle;

  assign req_tag = addr_tag(bus.address);
  assign req_idx = addr_index(bus.address);
  assign req_off = addr_offset(bus.address);
  assign req     = bus.read ^ bus.write;
  assign hit     = line_valid && (line_tag == req_tag);
  assign in_idle = (state_q == IDLE);

  // Gated by reset so the CPU is released the instant reset asserts
  assign bus.busywait      = reset && req && !(in_idle && hit);
  assign bus.readdata      = reset ? line_data[{req_off, 3'b000} +: 8] : 8'h00;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_addr_q;
  assign bus.mem_writedata = mem_wdata_q;

  cache_storage #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TAG_W),
    .IDX_W    (IDX_W)
  ) u_storage (
    .clock       (clock),
    .reset       (reset),
    .index_i     (req_idx),
    .offset_i    (req_off),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .data_o      (line_data),
    .byte_we_i   (in_idle && hit && bus.write && !bus.read),
    .byte_i      (bus.writedata),
    .fill_we_i   (state_q == UPDATE),
    .fill_tag_i  (req_tag),
    .fill_data_i (fill_q)
  );

  // held_q blocks a memory-state exit on the edge that entered it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      held_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      held_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            held_q <= 1'b0;
            if (line_valid && line_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, req_idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag, req_idx};
            end
          end
        end
        WRITEBACK: begin
          if (held_q && !bus.mem_busywait) begin
            state_q     <= FETCH;
            held_q      <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {req_tag, req_idx};
          end
        end
        FETCH: begin
          if (held_q && !bus.mem_busywait) begin
            state_q    <= UPDATE;
            mem_read_q <= 1'b0;
            fill_q     <= bus.mem_readdata;
          end
        end
        UPDATE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache_controller.sv
// tb/tb_data_cache_controller.sv - scoreboard bench for the data cache with a latency-modelled block memory
module tb_data_cache_controller;
  import cache_pkg::*;

  localparam int LAT         = 3;
  localparam int CLEAN_STALL = LAT + 3;
  localparam int DIRTY_STALL = CLEAN_STALL + LAT + 1;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_req_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  data_cache_controller_if bus();

  data_cache_controller #(.NUM_SETS(8), .TAG_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] blk_init(input int b);
    logic [7:0] base;
    base = 8'(b * 4);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base} ^ 32'hA5C3_5A3C;
  endfunction

  // Block memory: LAT edges of a held request complete a transfer
  logic [31:0] wmem [64];
  logic [63:0] written = '0;
  logic [1:0]  rd_cnt = '0;
  logic [1:0]  wr_cnt = '0;
  logic        rd_done = 1'b0;
  logic        wr_done = 1'b0;

  function automatic logic [31:0] mem_val(input logic [5:0] a);
    return written[a] ? wmem[a] : blk_init(int'(a));
  endfunction

  assign bus.mem_busywait = (bus.mem_read && !rd_done) || (bus.mem_write && !wr_done);

  always @(posedge clock) begin
    if (bus.mem_read && !rd_done) begin
      if (rd_cnt == 2'(LAT - 1)) begin
        rd_done          <= 1'b1;
        bus.mem_readdata <= mem_val(bus.mem_address);
      end else begin
        rd_cnt <= rd_cnt + 2'd1;
      end
    end else if (!bus.mem_read) begin
      rd_cnt  <= '0;
      rd_done <= 1'b0;
    end
    if (bus.mem_write && !wr_done) begin
      if (wr_cnt == 2'(LAT - 1)) begin
        wr_done                  <= 1'b1;
        wmem[bus.mem_address]    <= bus.mem_writedata;
        written[bus.mem_address] <= 1'b1;
      end else begin
        wr_cnt <= wr_cnt + 2'd1;
      end
    end else if (!bus.mem_write) begin
      wr_cnt  <= '0;
      wr_done <= 1'b0;
    end
  end

  // Reference cache and scoreboards
  logic        ref_valid [8];
  logic        ref_dirty [8];
  logic [2:0]  ref_tag   [8];
  logic [31:0] ref_data  [8];
  logic [31:0] ref_mem   [64];
  mem_req_t    exp_mem[$];
  logic [7:0]  exp_rd[$];

  task automatic mem_pop(input logic wr);
    mem_req_t e;
    check_eq("mem_req_expected", 32'(exp_mem.size() > 0), 32'd1);
    if (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      check_eq("mem_kind", {31'd0, wr}, {31'd0, e.wr});
      check_eq("mem_address", {26'd0, bus.mem_address}, {26'd0, e.addr});
      if (wr) check_eq("mem_writedata", bus.mem_writedata, e.data);
    end
  endtask

  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clock) begin
    if (bus.mem_write && !prev_wr) mem_pop(1'b1);
    if (bus.mem_read && !prev_rd) mem_pop(1'b0);
    prev_rd = bus.mem_read;
    prev_wr = bus.mem_write;
  end

  task automatic ref_access(input logic wr, input logic [7:0] a, input logic [7:0] wd, output int stall);
    int         idx;
    int         off;
    logic [2:0] tg;
    idx   = int'(a[4:2]);
    off   = int'(a[1:0]);
    tg    = a[7:5];
    stall = 0;
    if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
      stall = CLEAN_STALL;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        exp_mem.push_back('{1'b1, {ref_tag[idx], 3'(idx)}, ref_data[idx]});
        ref_mem[{ref_tag[idx], 3'(idx)}] = ref_data[idx];
        stall = DIRTY_STALL;
      end
      exp_mem.push_back('{1'b0, {tg, 3'(idx)}, 32'd0});
      ref_data[idx]  = ref_mem[{tg, 3'(idx)}];
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx]   = tg;
    end
    if (wr) begin
      ref_data[idx][off*8 +: 8] = wd;
      ref_dirty[idx] = 1'b1;
    end else begin
      exp_rd.push_back(ref_data[idx][off*8 +: 8]);
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [7:0] wd, input string tag);
    int exp_stall;
    int n;
    ref_access(wr, a, wd, exp_stall);
    @(negedge clock);
    bus.read      = !wr;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
    #1;
    n = 0;
    while (bus.busywait && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    check_eq({tag, "_stall"}, n, exp_stall);
    if (!wr) check_eq({tag, "_readdata"}, {24'd0, bus.readdata}, {24'd0, exp_rd.pop_front()});
    @(posedge clock);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) ref_mem[i] = blk_init(i);
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = '0;
      ref_data[i]  = '0;
    end
    bus.read      = 1'b1;
    bus.write     = 1'b0;
    bus.address   = 8'h05;
    bus.writedata = 8'h00;

    // Reset holds everything quiet even with a request pending
    #2;
    check_eq("rst_busywait", {31'd0, bus.busywait}, 32'd0);
    check_eq("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    check_eq("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    check_eq("rst_readdata", {24'd0, bus.readdata}, 32'd0);
    @(negedge clock);
    bus.read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    cpu_access(1'b0, 8'h05, 8'h00, "clean_miss_05");
    cpu_access(1'b1, 8'h05, 8'hAB, "write_hit_05");
    cpu_access(1'b0, 8'h05, 8'h00, "read_hit_05");
    cpu_access(1'b0, 8'hE5, 8'h00, "dirty_miss_e5");
    cpu_access(1'b0, 8'h05, 8'h00, "clean_remiss_05");
    cpu_access(1'b0, 8'h4A, 8'h00, "clean_miss_4a");

    // read and write together is no access
    @(negedge clock);
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.address   = 8'h05;
    bus.writedata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("both_busywait", {31'd0, bus.busywait}, 32'd0);
      check_eq("both_mem_req", {31'd0, bus.mem_read | bus.mem_write}, 32'd0);
      @(negedge clock);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    cpu_access(1'b0, 8'h05, 8'h00, "both_unchanged_05");

    // Reset in the middle of a fetch
    exp_mem.push_back('{1'b0, 6'h23, 32'd0});
    @(negedge clock);
    bus.read    = 1'b1;
    bus.address = 8'h8C;
    n = 0;
    while (!bus.mem_read && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("midrst_fetch_started", {31'd0, bus.mem_read}, 32'd1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_eq("midrst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    check_eq("midrst_busywait", {31'd0, bus.busywait}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    bus.read = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cpu_access(1'b0, 8'h8C, 8'h00, "midrst_remiss_8c");
    cpu_access(1'b0, 8'h05, 8'h00, "midrst_remiss_05");

    for (int i = 0; i < 24; i++) begin
      cpu_access(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), "rand");
    end

    repeat (4) @(negedge clock);
    check_eq("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    check_eq("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
